// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/response bundle for the RISC-V instruction encoder.
//   request : in_valid/in_ready, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm
//   response: out_valid/out_ready, out_instr, out_addr[ADDR_W]
//   sideband: addr_clr (reload address, clear error), imm_err (sticky error)
// slave modport is the encoder side; master is the producer/consumer side.
interface instr_encoder_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              addr_clr;
  logic              imm_err;

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
           out_ready, addr_clr,
    output in_ready, out_valid, out_instr, out_addr, imm_err
  );

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
           out_ready, addr_clr,
    input  in_ready, out_valid, out_instr, out_addr, imm_err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs format/register fields/immediate into a RISC-V word
// (LOAD, ALU-I, STORE, AUIPC) and queues it in a 2-entry valid/ready FIFO.
// Each popped word advances a byte address counter by 4.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - instr_encoder_if.slave (request, response, addr_clr, imm_err)
// Parameters: ADDR_W (address width, wraps mod 2^ADDR_W), BASE_ADDR.
// Optional feature macro: IMM_RANGE_CHECK_EN - out-of-range immediates are
// handshaken but dropped, and set the sticky imm_err flag.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t              state;
  logic [31:0]       head_q, tail_q;
  logic              vld_q, rdy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word;
  logic              push, pop, bad, enq;

  function automatic logic [31:0] enc(input logic [1:0] fmt, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [31:0] imm);
    logic [31:0] w;
    case (fmt)
      2'd0:    w = {imm[11:0], rs1, f3, rd, 7'b0000011};
      2'd1:    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
      2'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      default: w = {imm[31:12], rd, 7'b0010111};
    endcase
    return w;
  endfunction

  always_comb begin
    word = enc(bus.in_fmt, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3, bus.in_imm);
    push = bus.in_valid && rdy_q;
    pop  = vld_q && bus.out_ready;
`ifdef IMM_RANGE_CHECK_EN
    // U needs low 12 bits clear; I/S need [31:11] to be a pure sign extension
    if (bus.in_fmt == 2'd3) bad = |bus.in_imm[11:0];
    else                    bad = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
`else
    bad = 1'b0;
`endif
    // a rejected request still completes its handshake, it just never lands
    enq = push && !bad;
  end

  // occupancy FSM; head_q is the FIFO head and drives out_instr directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (enq) begin
          head_q <= word;
          vld_q  <= 1'b1;
          state  <= ONE;
        end
        ONE: case ({enq, pop})
          2'b10: begin
            tail_q <= word;
            rdy_q  <= 1'b0;
            state  <= FULL;
          end
          2'b01: begin
            vld_q <= 1'b0;
            state <= EMPTY;
          end
          2'b11: head_q <= word;
          default: ;
        endcase
        FULL: if (pop) begin
          head_q <= tail_q;
          rdy_q  <= 1'b1;
          state  <= ONE;
        end
        default: begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= EMPTY;
        end
      endcase
    end
  end

  // addr_clr has priority over the pop increment; wrap is natural overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               addr_q <= BASE_ADDR;
    else if (bus.addr_clr) addr_q <= BASE_ADDR;
    else if (pop)          addr_q <= addr_q + ADDR_W'(4);
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               err_q <= 1'b0;
    else if (bus.addr_clr) err_q <= 1'b0;
    else if (push && bad)  err_q <= 1'b1;
  end
  assign bus.imm_err = err_q;
`else
  assign bus.imm_err = 1'b0;
`endif

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_instr = head_q;
  assign bus.out_addr  = addr_q;

endmodule
